// File: rtl/pe1_stage_ctrl.sv
// Purpose : runs one NTT/INTT butterfly stage over an N-coefficient bank through a single PE1,
//           reading (u, v) pairs in place and writing bf_upper/bf_lower back to the same addresses.
// Latency : one pair issued per cycle; each write-back trails its read by RD_LAT+PE_LAT cycles;
//           done pulses one cycle after the last write. No backpressure: memory and PE1 are fixed-latency,
//           and start is ignored while busy.
// Ports   : clk/rst (sync, active-low); start/mode/log_len request; busy/done/sel status;
//           rd_en/rd_addr_u/rd_addr_v/rd_data_u/rd_data_v memory read side; pe_u/pe_v to PE1;
//           bf_upper/bf_lower from PE1; wr_en/wr_addr_u/wr_addr_v/wr_data_u/wr_data_v memory write side.
module pe1_stage_ctrl #(
   parameter int DW     = 12,
   parameter int N      = 256,
   parameter int AW     = 8,
   parameter int RD_LAT = 1,
   parameter int PE_LAT = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [2:0]    log_len,
   output logic          busy,
   output logic          done,
   output logic          sel,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr_u,
   output logic [AW-1:0] rd_addr_v,
   input  logic [DW-1:0] rd_data_u,
   input  logic [DW-1:0] rd_data_v,
   output logic [DW-1:0] pe_u,
   output logic [DW-1:0] pe_v,
   input  logic [DW-1:0] bf_upper,
   input  logic [DW-1:0] bf_lower,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr_u,
   output logic [AW-1:0] wr_addr_v,
   output logic [DW-1:0] wr_data_u,
   output logic [DW-1:0] wr_data_v
);

   // Write-back trails the read by memory + PE1 latency; must be at least 2.
   localparam int WB_LAT = RD_LAT + PE_LAT;
   localparam int KW     = AW - 1;
   localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            mode_q, mode_d;
   logic [2:0]      ll_q, ll_d;
   logic [AW-1:0]   au_q, au_d, av_q, av_d;

   // Write-back delay line: one valid bit and the pair's addresses per stage.
   logic [WB_LAT-1:0] dl_vld_q;
   logic [AW-1:0]     dl_u_q [WB_LAT];
   logic [AW-1:0]     dl_v_q [WB_LAT];

   // Pair k of a stage with half-span 2^ll: block index (k>>ll) spans 2*len
   // addresses, offset inside the block is k mod len. Returns {v, u}.
   function automatic logic [2*AW-1:0] pair_addr(input logic [KW-1:0] k, input logic [2:0] ll);
      logic [AW-1:0] kk, len, u;
      kk  = {1'b0, k};
      len = AW'(1) << ll;
      u   = ((kk >> ll) << ({1'b0, ll} + 4'd1)) | (kk & (len - AW'(1)));
      return {u + len, u};
   endfunction

   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      mode_d         = mode_q;
      ll_d           = ll_q;
      {av_d, au_d}   = {av_q, au_q};
      rd_en          = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               mode_d       = mode;
               ll_d         = log_len;
               k_d          = '0;
               {av_d, au_d} = pair_addr('0, log_len);
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_en = 1'b1;
            if (k_q == K_LAST) begin
               state_d = S_DRAIN;
            end else begin
               k_d          = k_q + KW'(1);
               {av_d, au_d} = pair_addr(k_q + KW'(1), ll_q);
            end
         end
         S_DRAIN: begin
            // Only the oldest stage may still hold a pair: it writes this
            // cycle, so the next cycle is the completion cycle.
            if (dl_vld_q[WB_LAT-2:0] == '0) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         mode_q   <= 1'b0;
         ll_q     <= '0;
         au_q     <= '0;
         av_q     <= '0;
         dl_vld_q <= '0;
         for (int i = 0; i < WB_LAT; i++) begin
            dl_u_q[i] <= '0;
            dl_v_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         mode_q   <= mode_d;
         ll_q     <= ll_d;
         au_q     <= au_d;
         av_q     <= av_d;
         dl_vld_q <= {dl_vld_q[WB_LAT-2:0], rd_en};
         dl_u_q[0] <= au_q;
         dl_v_q[0] <= av_q;
         for (int i = 1; i < WB_LAT; i++) begin
            dl_u_q[i] <= dl_u_q[i-1];
            dl_v_q[i] <= dl_v_q[i-1];
         end
      end
   end

   // sel keeps the latched mode through drain and past done.
   assign sel       = mode_q;
   assign rd_addr_u = au_q;
   assign rd_addr_v = av_q;
   assign pe_u      = rd_data_u;
   assign pe_v      = rd_data_v;
   assign wr_en     = dl_vld_q[WB_LAT-1];
   assign wr_addr_u = dl_u_q[WB_LAT-1];
   assign wr_addr_v = dl_v_q[WB_LAT-1];
   assign wr_data_u = bf_upper;
   assign wr_data_v = bf_lower;

endmodule

// File: tb/tb_pe1_stage_ctrl.sv
// Purpose : self-checking bench for pe1_stage_ctrl with a RAM model and a fixed-latency PE1 stub.
// Latency : checks every cycle of each stage against the stage timing windows and an address/data model.
// Ports   : drives clk/rst/start/mode/log_len; the RAM and PE1 models close the data loop.
module tb_pe1_stage_ctrl;
   localparam int DW = 12, N = 256, AW = 8, RD_LAT = 1, PE_LAT = 6;
   localparam int Q  = 3329;

   logic          clk, rst, start, mode;
   logic [2:0]    log_len;
   logic          busy, done, sel, rd_en, wr_en;
   logic [AW-1:0] rd_addr_u, rd_addr_v, wr_addr_u, wr_addr_v;
   logic [DW-1:0] rd_data_u, rd_data_v, pe_u, pe_v, bf_upper, bf_lower, wr_data_u, wr_data_v;

   pe1_stage_ctrl #(.DW(DW), .N(N), .AW(AW), .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .log_len(log_len),
      .busy(busy), .done(done), .sel(sel),
      .rd_en(rd_en), .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v),
      .rd_data_u(rd_data_u), .rd_data_v(rd_data_v),
      .pe_u(pe_u), .pe_v(pe_v), .bf_upper(bf_upper), .bf_lower(bf_lower),
      .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v),
      .wr_data_u(wr_data_u), .wr_data_v(wr_data_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cur_r = 0;

   // PE1 stub: NTT gives (u+v, u-v), INTT gives (u+v, v-u), all mod q.
   function automatic logic [DW-1:0] bf_hi(input logic [DW-1:0] u, input logic [DW-1:0] v, input logic s);
      if (s) return DW'((int'(u) + int'(v)) % Q);
      return DW'((int'(u) + int'(v)) % Q);
   endfunction
   function automatic logic [DW-1:0] bf_lo(input logic [DW-1:0] u, input logic [DW-1:0] v, input logic s);
      if (s) return DW'((int'(v) - int'(u) + Q) % Q);
      return DW'((int'(u) - int'(v) + Q) % Q);
   endfunction

   // RAM (RD_LAT=1) and PE1 pipeline (PE_LAT stages) environment.
   logic [DW-1:0] mem      [N];
   logic [DW-1:0] init_img [N];
   logic          init_req;
   logic [DW-1:0] pipe_u [PE_LAT];
   logic [DW-1:0] pipe_l [PE_LAT];

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < N; i++) mem[i] <= init_img[i];
      end else if (wr_en) begin
         mem[wr_addr_u] <= wr_data_u;
         mem[wr_addr_v] <= wr_data_v;
      end
      if (rd_en) begin
         rd_data_u <= mem[rd_addr_u];
         rd_data_v <= mem[rd_addr_v];
      end
      pipe_u[0] <= bf_hi(pe_u, pe_v, sel);
      pipe_l[0] <= bf_lo(pe_u, pe_v, sel);
      for (int i = 1; i < PE_LAT; i++) begin
         pipe_u[i] <= pipe_u[i-1];
         pipe_l[i] <= pipe_l[i-1];
      end
   end
   assign bf_upper = pipe_u[PE_LAT-1];
   assign bf_lower = pipe_l[PE_LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s r=%0d observed=%0d expected=%0d", tag, cur_r, obs, exp);
      end
   endtask

   // One stage. sa/sb: cycles with an extra start pulse (0 = none); rst_at: cycle with rst=0
   // (0 = none); post: extra idle cycles checked after done; dir: seed mem[0..1] = 5, 3328.
   task automatic run_stage(input logic m, input logic [2:0] ll, input int sa, input int sb,
                            input int rst_at, input int post, input bit dir);
      int len, nh, wb, last, bad, a, b;
      bit alive, e_rd, e_wr;
      int pu[$];
      int wcnt [N];
      logic [DW-1:0] refm [N];
      len = 1 << ll;
      nh  = N / 2;
      wb  = RD_LAT + PE_LAT;
      // Pairs in issue order: each 2*len block contributes (j, j+len) for its lower half.
      for (int blk = 0; blk < N; blk += 2 * len)
         for (int j = 0; j < len; j++) pu.push_back(blk + j);
      for (int i = 0; i < N; i++) begin
         init_img[i] = DW'($urandom_range(Q - 1));
         wcnt[i] = 0;
      end
      if (dir) begin
         init_img[0] = DW'(5);
         init_img[1] = DW'(3328);
      end
      refm = init_img;
      foreach (pu[i]) begin
         a = refm[pu[i]];
         b = refm[pu[i] + len];
         refm[pu[i]]       = bf_hi(DW'(a), DW'(b), m);
         refm[pu[i] + len] = bf_lo(DW'(a), DW'(b), m);
      end
      @(negedge clk);
      init_req = 1'b1;
      start    = 1'b1;
      mode     = m;
      log_len  = ll;
      rst      = 1'b1;
      last = (rst_at != 0) ? rst_at + 12 : nh + wb + 1 + post;
      for (int r = 1; r <= last; r++) begin
         @(negedge clk);
         cur_r = r;
         alive = (rst_at == 0) || (r <= rst_at);
         e_rd  = alive && (r <= nh);
         e_wr  = alive && (r >= 1 + wb) && (r <= nh + wb);
         chk("busy",  busy,  32'(alive && (r <= nh + wb + 1)));
         chk("done",  done,  32'(alive && (r == nh + wb + 1)));
         chk("rd_en", rd_en, 32'(e_rd));
         chk("wr_en", wr_en, 32'(e_wr));
         if (alive) chk("sel", sel, 32'(m));
         if (e_rd) begin
            chk("rd_addr_u", rd_addr_u, pu[r-1]);
            chk("rd_addr_v", rd_addr_v, pu[r-1] + len);
         end
         if (e_wr) begin
            chk("wr_addr_u", wr_addr_u, pu[r-1-wb]);
            chk("wr_addr_v", wr_addr_v, pu[r-1-wb] + len);
         end
         if (wr_en) begin
            wcnt[wr_addr_u]++;
            wcnt[wr_addr_v]++;
         end
         init_req = 1'b0;
         start    = (r == sa) || (r == sb);
         if (start) begin
            mode    = ~m;
            log_len = ll + 3'd1;
         end
         rst = (r == rst_at) ? 1'b0 : 1'b1;
      end
      start = 1'b0;
      rst   = 1'b1;
      if (rst_at == 0) begin
         bad = 0;
         for (int i = 0; i < N; i++) if (wcnt[i] != 1) bad++;
         chk("wr_once", bad, 0);
         for (int i = 0; i < N; i++) chk("mem", mem[i], refm[i]);
         if (dir) begin
            chk("mem0_dir", mem[0], 4);
            chk("mem1_dir", mem[1], 6);
         end
      end
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      mode     = 1'b0;
      log_len  = 3'd0;
      init_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_sel",   sel, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_u",  rd_addr_u, 0);
      chk("rst_rd_v",  rd_addr_v, 0);
      chk("rst_wr_u",  wr_addr_u, 0);
      chk("rst_wr_v",  wr_addr_v, 0);
      rst = 1'b1;

      // NTT, len=1, directed data; the next stage starts the cycle after done.
      run_stage(1'b0, 3'd0, 0, 0, 0, 0, 1'b1);
      run_stage(1'b0, 3'd7, 0, 0, 0, 0, 1'b0);
      // INTT, len=8, stray starts at cycle 20 and in the done cycle.
      run_stage(1'b1, 3'd3, 20, 136, 0, 4, 1'b0);
      // Abort at cycle 50, then restart with random stages.
      run_stage(1'b1, 3'($urandom_range(7)), 0, 0, 50, 0, 1'b0);
      for (int i = 0; i < 5; i++)
         run_stage(1'($urandom_range(1)), 3'($urandom_range(7)), 0, 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pe1_stage_ctrl.md
Name: pe1_stage_ctrl

Overview:
- Drives one full NTT/INTT butterfly stage over an N-coefficient bank through a single PE1 butterfly.
- Reads coefficient pairs (u at j, v at j+len) from a dual-read coefficient memory and feeds them to PE1.
- Tracks the fixed memory and PE1 latency with a valid/address delay line and writes bf_upper/bf_lower back in place.
- Sits between the coefficient RAM and PE1, under the NTT top-level stage sequencer.

Parameters:
DW, 12, coefficient width (q = 3329)
N, 256, coefficients per polynomial
AW, 8, address width (log2 N)
RD_LAT, 1, memory read latency in cycles
PE_LAT, 6, PE1 latency in cycles, u/v in to bf_upper/bf_lower out

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst=0 resets on the clock edge)
start  in  1  one-cycle request to run a stage; ignored while busy=1
mode  in  1  0=NTT, 1=INTT; latched at accepted start
log_len  in  3  butterfly half-span, len = 1<<log_len (1..128); latched at accepted start
busy  out  1  stage in progress
done  out  1  one-cycle pulse when the last write-back has completed
sel  out  1  latched mode, drives PE1 sel
rd_en  out  1  read strobe to coefficient memory
rd_addr_u  out  AW  u address
rd_addr_v  out  AW  v address
rd_data_u  in  DW  memory data for u, valid RD_LAT after rd_en
rd_data_v  in  DW  memory data for v
pe_u  out  DW  combinational pass-through of rd_data_u to PE1 u
pe_v  out  DW  combinational pass-through of rd_data_v to PE1 v
bf_upper  in  DW  PE1 upper output
bf_lower  in  DW  PE1 lower output
wr_en  out  1  write strobe, both ports
wr_addr_u  out  AW  write address for bf_upper
wr_addr_v  out  AW  write address for bf_lower
wr_data_u  out  DW  = bf_upper (combinational)
wr_data_v  out  DW  = bf_lower (combinational)

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - busy, done, sel, rd_en and wr_en are 0.
  - Addresses and pair counter are 0.
  - All delay-line valid bits are cleared.
- Mid-operation reset aborts the stage immediately: no further rd_en or wr_en, and no done pulse.
- FSM:
  - IDLE: start=1 latches mode and log_len, clears k, and moves to ISSUE. busy=1 from the next cycle.
  - ISSUE: one pair per cycle, rd_en=1, k from 0 to N/2-1. After k=N/2-1 is issued, move to DRAIN.
  - DRAIN: rd_en=0. Wait until the delay line is empty (last wr_en done), then move to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE.
- Address generation (len = 1<<log_len):
  - rd_addr_u = ((k>>log_len)<<(log_len+1)) | (k & (len-1))
  - rd_addr_v = rd_addr_u + len
  - Both are registered and presented in the same cycle as rd_en.
- Write-back timing:
  - A pair read in cycle t gets wr_en in cycle t+RD_LAT+PE_LAT (t+7 at defaults).
  - wr_addr_u/wr_addr_v are the rd addresses of cycle t, carried through a WB_LAT-deep shift register with a valid bit.
- Write data is not registered here; PE1 output is forwarded directly.
- Stage timing: with start accepted at edge 0:
  - rd_en is high for cycles 1..N/2 (1..128).
  - wr_en is high for cycles 8..135.
  - done pulses in cycle 136.
  - busy is high for cycles 1..136.
- sel holds the latched mode from cycle 1 until the next accepted start. It is not reset by done, so PE1 stays in a consistent mode during drain.
- start during busy (including the DONE cycle) is ignored: no relatch and no restart.
- Back-to-back: start in the cycle after done is accepted normally.
- Each address appears exactly once per stage across the u/v ports. No read-after-write hazard exists within a stage because read/write sets are disjoint per pair.

Test Plan:
- log_len=0, NTT: first rd pairs (0,1),(2,3),(4,5); last (254,255); 128 rd_en cycles; done at cycle 136.
- log_len=7: pairs (0,128),(1,129)…(127,255); wr_addr_u/v on cycle 8 = (0,128), on cycle 135 = (127,255).
- log_len=3: k=8 → (16,24), k=15 → (23,31); a scoreboard confirms every address 0..255 is written exactly once.
- End to end with RAM model + PE1 in NTT mode: mem[0]=5, mem[1]=3328 → after stage, mem[0]=4, mem[1]=6.
- In INTT mode, results match the golden model per pe1_intt vectors.
- start pulsed at cycles 20 and 136 during a stage → ignored: rd_en count stays 128 and a single done.
- start at cycle 137 starts a new stage.
- rst=0 at cycle 50 → wr_en, rd_en, busy = 0 from cycle 51; no done.
- Restart after reset completes normally with correct addresses.
